// File: rtl/traffic_light_controller_param.sv
// Highway/farm traffic light FSM with configurable phase lengths and all-red clearance.
// Define TLC_PED_EN to enable the pedestrian request / walk feature.
module traffic_light_controller_param #(
    parameter int unsigned TIMER_W        = 8,
    parameter int unsigned MIN_GREEN      = 20,
    parameter int unsigned MAX_FARM_GREEN = 40,
    parameter int unsigned YELLOW_TIME    = 5,
    parameter int unsigned ALL_RED_TIME   = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sensor,
    input  logic       ped_req,
    output logic [1:0] highway_light,
    output logic [1:0] farm_light,
    output logic       walk,
    output logic [2:0] phase
);

    typedef enum logic [2:0] {
        StHgre  = 3'd0,
        StHyel  = 3'd1,
        StAred1 = 3'd2,
        StFgre  = 3'd3,
        StFyel  = 3'd4,
        StAred2 = 3'd5
    } state_e;

    localparam logic [1:0] LightGreen  = 2'b00;
    localparam logic [1:0] LightYellow = 2'b01;
    localparam logic [1:0] LightRed    = 2'b10;

    // Farm green held this long against a sensor drop when a pedestrian caused the change
    localparam int unsigned PedHold = (MIN_GREEN < MAX_FARM_GREEN) ? MIN_GREEN : MAX_FARM_GREEN;

    state_e             state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [1:0]         highway_d, farm_d;
    logic               walk_d;
    logic               ped_pending_q, ped_pending_d;
    logic               ped_cause_q, ped_cause_d;
    logic               expired, farm_hold_done;
    logic [TIMER_W:0]   farm_count;

    function automatic logic [TIMER_W-1:0] load_value(input state_e s);
        int unsigned dur;
        case (s)
            StHgre:         dur = MIN_GREEN;
            StHyel, StFyel: dur = YELLOW_TIME;
            StFgre:         dur = MAX_FARM_GREEN;
            default:        dur = ALL_RED_TIME;
        endcase
        return TIMER_W'(dur - 1);
    endfunction

    always_comb begin
        expired        = (timer_q == '0);
        // Cycles spent in farm green so far, counting the current one
        farm_count     = (TIMER_W+1)'(MAX_FARM_GREEN) - {1'b0, timer_q};
        farm_hold_done = ped_cause_q ? (farm_count >= (TIMER_W+1)'(PedHold)) : 1'b1;

        state_d = state_q;
        case (state_q)
            StHgre:  if (expired && (sensor || ped_pending_q)) state_d = StHyel;
            StHyel:  if (expired) state_d = StAred1;
            StAred1: if (expired) state_d = StFgre;
            StFgre:  if ((!sensor && farm_hold_done) || expired) state_d = StFyel;
            StFyel:  if (expired) state_d = StAred2;
            StAred2: if (expired) state_d = StHgre;
            default: state_d = StAred2;
        endcase

        if (state_d != state_q) begin
            timer_d = load_value(state_d);
        end else if (expired) begin
            timer_d = '0;
        end else begin
            timer_d = timer_q - TIMER_W'(1);
        end

        highway_d = LightRed;
        farm_d    = LightRed;
        case (state_d)
            StHgre:  highway_d = LightGreen;
            StHyel:  highway_d = LightYellow;
            StFgre:  farm_d    = LightGreen;
            StFyel:  farm_d    = LightYellow;
            default: ;
        endcase
    end

`ifdef TLC_PED_EN
    logic leave_hgre;

    always_comb begin
        leave_hgre    = (state_q == StHgre) && (state_d == StHyel);
        ped_pending_d = leave_hgre ? 1'b0 : (ped_pending_q | ped_req);
        ped_cause_d   = leave_hgre ? ped_pending_q : ped_cause_q;
        walk_d        = (state_d == StFgre);
    end
`else
    logic unused_ped_req;

    assign unused_ped_req = ped_req;
    assign ped_pending_d  = 1'b0;
    assign ped_cause_d    = 1'b0;
    assign walk_d         = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= StHgre;
            timer_q       <= load_value(StHgre);
            ped_pending_q <= 1'b0;
            ped_cause_q   <= 1'b0;
            highway_light <= LightGreen;
            farm_light    <= LightRed;
            walk          <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            ped_pending_q <= ped_pending_d;
            ped_cause_q   <= ped_cause_d;
            highway_light <= highway_d;
            farm_light    <= farm_d;
            walk          <= walk_d;
        end
    end

    assign phase = state_q;

endmodule

// File: tb/tb_traffic_light_controller_param.sv
// Self-checking bench for traffic_light_controller_param: directed vector table,
// hand-written corner sequences and randomized traffic against a cycle-count model.
module tb_traffic_light_controller_param;

    localparam int unsigned TimerW   = 4;
    localparam int unsigned MinGreen = 4;
    localparam int unsigned MaxFarm  = 6;
    localparam int unsigned Yellow   = 2;
    localparam int unsigned AllRed   = 1;
`ifdef TLC_PED_EN
    localparam bit PedEn = 1'b1;
`else
    localparam bit PedEn = 1'b0;
`endif
    localparam logic [1:0] G = 2'b00;
    localparam logic [1:0] Y = 2'b01;
    localparam logic [1:0] R = 2'b10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sensor = 1'b0;
    logic       ped_req = 1'b0;
    logic [1:0] highway_light, farm_light;
    logic       walk;
    logic [2:0] phase;

    int n_cmp = 0;
    int n_err = 0;
    bit use_model = 1'b0;

    traffic_light_controller_param #(
        .TIMER_W       (TimerW),
        .MIN_GREEN     (MinGreen),
        .MAX_FARM_GREEN(MaxFarm),
        .YELLOW_TIME   (Yellow),
        .ALL_RED_TIME  (AllRed)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sensor       (sensor),
        .ped_req      (ped_req),
        .highway_light(highway_light),
        .farm_light   (farm_light),
        .walk         (walk),
        .phase        (phase)
    );

    always #5 clk = ~clk;

    // Reference model: phase index plus cycles spent in it (including the current one)
    int m_phase = 0;
    int m_cnt   = 1;
    bit m_pend  = 1'b0;
    bit m_cause = 1'b0;
    int dur[6]  = '{MinGreen, Yellow, AllRed, MaxFarm, Yellow, AllRed};

    function automatic logic [1:0] hw_of(input int ph);
        case (ph)
            0:       return G;
            1:       return Y;
            default: return R;
        endcase
    endfunction

    function automatic logic [1:0] farm_of(input int ph);
        case (ph)
            3:       return G;
            4:       return Y;
            default: return R;
        endcase
    endfunction

    task automatic model_step(input bit r, input bit s, input bit p);
        int  next;
        bit  done;
        int  hold;
        if (!r) begin
            m_phase = 0;
            m_cnt   = 1;
            m_pend  = 1'b0;
            m_cause = 1'b0;
            return;
        end
        done = (m_cnt >= dur[m_phase]);
        hold = m_cause ? ((MinGreen < MaxFarm) ? MinGreen : MaxFarm) : 1;
        next = m_phase;
        case (m_phase)
            0:       if (done && (s || m_pend)) next = 1;
            3:       if ((!s && m_cnt >= hold) || done) next = 4;
            default: if (done) next = (m_phase + 1) % 6;
        endcase
        if (PedEn) begin
            if (m_phase == 0 && next == 1) begin
                m_cause = m_pend;
                m_pend  = 1'b0;
            end else begin
                m_pend = m_pend | p;
            end
        end
        m_cnt   = (next != m_phase) ? 1 : m_cnt + 1;
        m_phase = next;
    endtask

    task automatic check(input string name, input logic [2:0] ep, input logic [1:0] eh,
                         input logic [1:0] ef, input logic ew);
        n_cmp++;
        if (phase !== ep || highway_light !== eh || farm_light !== ef || walk !== ew) begin
            n_err++;
            $display("FAIL %s @%0t: got phase=%0d hw=%b farm=%b walk=%b, want phase=%0d hw=%b farm=%b walk=%b",
                     name, $time, phase, highway_light, farm_light, walk, ep, eh, ef, ew);
        end
    endtask

    task automatic check_safety();
        n_cmp++;
        if ((highway_light == G && farm_light != R) || (farm_light == G && highway_light != R)) begin
            n_err++;
            $display("FAIL safety @%0t: got hw=%b farm=%b, required one road red while other is green",
                     $time, highway_light, farm_light);
        end
    endtask

    task automatic tick(input bit r, input bit s, input bit p);
        rst_n   = r;
        sensor  = s;
        ped_req = p;
        @(posedge clk);
        model_step(r, s, p);
        @(negedge clk);
        check_safety();
        if (use_model) begin
            check("model", 3'(m_phase), hw_of(m_phase), farm_of(m_phase),
                  PedEn && (m_phase == 3));
        end
    endtask

    typedef struct packed {
        logic       rst_n;
        logic       sensor;
        logic [2:0] phase;
        logic [1:0] hw;
        logic [1:0] farm;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic s, input logic [2:0] ph,
                                input logic [1:0] hw, input logic [1:0] fm);
        vec_t v;
        v.rst_n  = r;
        v.sensor = s;
        v.phase  = ph;
        v.hw     = hw;
        v.farm   = fm;
        return v;
    endfunction

    vec_t vecs[$];
    int   ped_seq[17] = '{0, 0, 0, 1, 1, 2, 3, 3, 3, 3, 4, 4, 5, 0, 0, 0, 0};

    initial begin
        // Reset, highway->farm handover, capped farm green, return, sensor drop, reset in HYEL
        vecs.push_back(mk(0, 1, 0, G, R));
        for (int i = 0; i < 3; i++) vecs.push_back(mk(1, 1, 0, G, R));
        vecs.push_back(mk(1, 1, 1, Y, R));
        vecs.push_back(mk(1, 1, 1, Y, R));
        vecs.push_back(mk(1, 1, 2, R, R));
        for (int i = 0; i < 6; i++) vecs.push_back(mk(1, 1, 3, R, G));
        vecs.push_back(mk(1, 1, 4, R, Y));
        vecs.push_back(mk(1, 1, 4, R, Y));
        vecs.push_back(mk(1, 1, 5, R, R));
        for (int i = 0; i < 4; i++) vecs.push_back(mk(1, 1, 0, G, R));
        vecs.push_back(mk(1, 1, 1, Y, R));
        vecs.push_back(mk(1, 1, 1, Y, R));
        vecs.push_back(mk(1, 1, 2, R, R));
        vecs.push_back(mk(1, 1, 3, R, G));
        vecs.push_back(mk(1, 1, 3, R, G));
        vecs.push_back(mk(1, 1, 3, R, G));
        vecs.push_back(mk(1, 0, 4, R, Y));
        vecs.push_back(mk(1, 0, 4, R, Y));
        vecs.push_back(mk(1, 0, 5, R, R));
        vecs.push_back(mk(1, 0, 0, G, R));
        for (int i = 0; i < 3; i++) vecs.push_back(mk(1, 1, 0, G, R));
        vecs.push_back(mk(1, 1, 1, Y, R));
        vecs.push_back(mk(0, 1, 0, G, R));
        for (int i = 0; i < 3; i++) vecs.push_back(mk(1, 1, 0, G, R));
        vecs.push_back(mk(1, 1, 1, Y, R));

        for (int i = 0; i < vecs.size(); i++) begin
            tick(vecs[i].rst_n, vecs[i].sensor, 1'b0);
            check($sformatf("table[%0d]", i), vecs[i].phase, vecs[i].hw, vecs[i].farm,
                  PedEn && (vecs[i].phase == 3'd3));
        end

        // Short sensor pulse before min-green expiry must not leave highway green
        tick(1'b0, 1'b0, 1'b0);
        check("sensor_pulse_reset", 3'd0, G, R, 1'b0);
        for (int i = 0; i < 20; i++) begin
            tick(1'b1, (i == 1), 1'b0);
            check($sformatf("sensor_pulse[%0d]", i), 3'd0, G, R, 1'b0);
        end

        // Single-cycle pedestrian request with no vehicle
        tick(1'b0, 1'b0, 1'b0);
        check("ped_reset", 3'd0, G, R, 1'b0);
        for (int i = 0; i < 17; i++) begin
            int ph;
            ph = PedEn ? ped_seq[i] : 0;
            tick(1'b1, 1'b0, (i == 0));
            check($sformatf("ped[%0d]", i), 3'(ph), hw_of(ph), farm_of(ph), PedEn && (ph == 3));
        end

        // Randomized traffic against the model
        use_model = 1'b1;
        begin
            bit s;
            bit p;
            bit r;
            s = 1'b0;
            tick(1'b0, 1'b0, 1'b0);
            for (int i = 0; i < 4000; i++) begin
                if ($urandom_range(0, 7) == 0) s = ~s;
                p = ($urandom_range(0, 29) == 0);
                r = ($urandom_range(0, 299) != 0);
                tick(r, s, p);
            end
        end
        use_model = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
